// File: rtl/taliesin_regfile_sb.sv
// rtl/taliesin_regfile_sb.sv - Taliesin 2R/2W register file with busy scoreboard
// r0 is hardwired to zero; wr1 (load) outranks wr0 (ALU) on collisions and bypass.
module taliesin_regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int BYPASS = 1
) (
   input  logic                   clk,
   input  logic                   rst_b,
   input  logic [ADDR_W-1:0]      rd_a_num,
   input  logic [ADDR_W-1:0]      rd_b_num,
   output logic [DATA_W-1:0]      rd_a_data,
   output logic [DATA_W-1:0]      rd_b_data,
   output logic                   rd_a_busy,
   output logic                   rd_b_busy,
   input  logic                   wr0_we,
   input  logic [ADDR_W-1:0]      wr0_num,
   input  logic [DATA_W-1:0]      wr0_data,
   input  logic                   wr1_we,
   input  logic [ADDR_W-1:0]      wr1_num,
   input  logic [DATA_W-1:0]      wr1_data,
   input  logic                   iss_en,
   input  logic [ADDR_W-1:0]      iss_num,
   output logic [(2**ADDR_W)-1:0] busy_vec
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0]   store_q [NUM_REGS];
   logic [DATA_W-1:0]   store_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   logic wr0_act;
   logic wr1_act;

   assign wr0_act  = wr0_we && (wr0_num != '0);
   assign wr1_act  = wr1_we && (wr1_num != '0);
   assign busy_vec = busy_q;

   // wr1 is applied last so it wins when both ports hit the same register
   always_comb begin
      store_d = store_q;
      if (wr0_act) store_d[wr0_num] = wr0_data;
      if (wr1_act) store_d[wr1_num] = wr1_data;
   end

   // A fresh issue supersedes a completing writeback to the same register
   always_comb begin
      busy_d    = busy_q;
      busy_d[0] = 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (iss_en && (iss_num == ADDR_W'(i))) begin
            busy_d[i] = 1'b1;
         end else if ((wr0_we && (wr0_num == ADDR_W'(i))) ||
                      (wr1_we && (wr1_num == ADDR_W'(i)))) begin
            busy_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < NUM_REGS; i++) store_q[i] <= '0;
         busy_q <= '0;
      end else begin
         store_q <= store_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      rd_a_data = '0;
      rd_a_busy = 1'b0;
      if (rd_a_num != '0) begin
         if ((BYPASS != 0) && wr1_we && (wr1_num == rd_a_num)) begin
            rd_a_data = wr1_data;
         end else if ((BYPASS != 0) && wr0_we && (wr0_num == rd_a_num)) begin
            rd_a_data = wr0_data;
         end else begin
            rd_a_data = store_q[rd_a_num];
            rd_a_busy = busy_q[rd_a_num];
         end
      end
   end

   always_comb begin
      rd_b_data = '0;
      rd_b_busy = 1'b0;
      if (rd_b_num != '0) begin
         if ((BYPASS != 0) && wr1_we && (wr1_num == rd_b_num)) begin
            rd_b_data = wr1_data;
         end else if ((BYPASS != 0) && wr0_we && (wr0_num == rd_b_num)) begin
            rd_b_data = wr0_data;
         end else begin
            rd_b_data = store_q[rd_b_num];
            rd_b_busy = busy_q[rd_b_num];
         end
      end
   end

endmodule

// File: tb/tb_taliesin_regfile_sb.sv
// tb/tb_taliesin_regfile_sb.sv - directed bench for taliesin_regfile_sb
// Two instances share stimulus: u_byp forwards writes, u_nob does not.
module tb_taliesin_regfile_sb;

   logic        clk;
   logic        rst_b;
   logic [3:0]  rd_a_num, rd_b_num;
   logic        wr0_we, wr1_we, iss_en;
   logic [3:0]  wr0_num, wr1_num, iss_num;
   logic [31:0] wr0_data, wr1_data;

   logic [31:0] byp_a_data, byp_b_data, nob_a_data, nob_b_data;
   logic        byp_a_busy, byp_b_busy, nob_a_busy, nob_b_busy;
   logic [15:0] byp_busy_vec, nob_busy_vec;

   int checks = 0;
   int errors = 0;

   taliesin_regfile_sb #(.DATA_W(32), .ADDR_W(4), .BYPASS(1)) u_byp (
      .clk(clk), .rst_b(rst_b),
      .rd_a_num(rd_a_num), .rd_b_num(rd_b_num),
      .rd_a_data(byp_a_data), .rd_b_data(byp_b_data),
      .rd_a_busy(byp_a_busy), .rd_b_busy(byp_b_busy),
      .wr0_we(wr0_we), .wr0_num(wr0_num), .wr0_data(wr0_data),
      .wr1_we(wr1_we), .wr1_num(wr1_num), .wr1_data(wr1_data),
      .iss_en(iss_en), .iss_num(iss_num), .busy_vec(byp_busy_vec)
   );

   taliesin_regfile_sb #(.DATA_W(32), .ADDR_W(4), .BYPASS(0)) u_nob (
      .clk(clk), .rst_b(rst_b),
      .rd_a_num(rd_a_num), .rd_b_num(rd_b_num),
      .rd_a_data(nob_a_data), .rd_b_data(nob_b_data),
      .rd_a_busy(nob_a_busy), .rd_b_busy(nob_b_busy),
      .wr0_we(wr0_we), .wr0_num(wr0_num), .wr0_data(wr0_data),
      .wr1_we(wr1_we), .wr1_num(wr1_num), .wr1_data(wr1_data),
      .iss_en(iss_en), .iss_num(iss_num), .busy_vec(nob_busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr0_we = 1'b0; wr1_we = 1'b0; iss_en = 1'b0;
   endtask

   initial begin
      rst_b = 1'b0;
      rd_a_num = '0; rd_b_num = '0;
      wr0_we = 1'b0; wr0_num = '0; wr0_data = '0;
      wr1_we = 1'b0; wr1_num = '0; wr1_data = '0;
      iss_en = 1'b0; iss_num = '0;
      tick(); tick();
      rd_a_num = 4'd5; rd_b_num = 4'd7;
      #1;
      chk("reset_rd_a_data", byp_a_data, 64'h0);
      chk("reset_busy_vec", byp_busy_vec, 64'h0);
      chk("reset_rd_b_busy", nob_b_busy, 64'h0);
      rst_b = 1'b1;
      tick();

      // 1: basic write/read, r0 write ignored
      wr0_we = 1'b1; wr0_num = 4'd5; wr0_data = 32'hDEADBEEF;
      tick(); idle();
      chk("t1_r5_data", nob_a_data, 64'hDEADBEEF);
      chk("t1_r5_busy", nob_a_busy, 64'h0);
      rd_a_num = 4'd0;
      wr0_we = 1'b1; wr0_num = 4'd0; wr0_data = 32'h1234;
      #1;
      chk("t1_r0_bypass", byp_a_data, 64'h0);
      tick(); idle();
      chk("t1_r0_byp", byp_a_data, 64'h0);
      chk("t1_r0_nob", nob_a_data, 64'h0);

      // 2: same-register collision, wr1 wins
      wr0_we = 1'b1; wr0_num = 4'd3; wr0_data = 32'h11111111;
      wr1_we = 1'b1; wr1_num = 4'd3; wr1_data = 32'h22222222;
      rd_a_num = 4'd3;
      #1;
      chk("t2_bypass_prio", byp_a_data, 64'h22222222);
      tick(); idle();
      chk("t2_r3_nob", nob_a_data, 64'h22222222);
      chk("t2_r3_byp", byp_a_data, 64'h22222222);

      // 3: same-cycle bypass vs. none
      wr1_we = 1'b1; wr1_num = 4'd7; wr1_data = 32'hCAFEF00D;
      #1;
      chk("t3_byp_same", byp_b_data, 64'hCAFEF00D);
      chk("t3_nob_same", nob_b_data, 64'h0);
      tick(); idle();
      chk("t3_nob_next", nob_b_data, 64'hCAFEF00D);

      // 4: issue marks busy, writeback clears it
      iss_en = 1'b1; iss_num = 4'd9;
      tick(); idle();
      rd_a_num = 4'd9;
      #1;
      chk("t4_busy_vec", byp_busy_vec, 64'h0200);
      chk("t4_byp_busy", byp_a_busy, 64'h1);
      chk("t4_nob_busy", nob_a_busy, 64'h1);
      wr0_we = 1'b1; wr0_num = 4'd9; wr0_data = 32'h99;
      #1;
      chk("t4_byp_busy_wr", byp_a_busy, 64'h0);
      chk("t4_byp_data_wr", byp_a_data, 64'h99);
      chk("t4_nob_busy_wr", nob_a_busy, 64'h1);
      tick(); idle();
      chk("t4_busy_clr", nob_busy_vec, 64'h0);
      chk("t4_nob_busy_after", nob_a_busy, 64'h0);
      chk("t4_nob_data_after", nob_a_data, 64'h99);

      // 5: issue beats a same-cycle writeback; r0 never busy
      iss_en = 1'b1; iss_num = 4'd4;
      tick(); idle();
      iss_en = 1'b1; iss_num = 4'd4;
      wr1_we = 1'b1; wr1_num = 4'd4; wr1_data = 32'h55;
      tick(); idle();
      rd_a_num = 4'd4;
      #1;
      chk("t5_busy_vec", nob_busy_vec, 64'h0010);
      chk("t5_r4_data", nob_a_data, 64'h55);
      chk("t5_r4_busy", byp_a_busy, 64'h1);
      iss_en = 1'b1; iss_num = 4'd0;
      tick(); idle();
      chk("t5_r0_not_busy", byp_busy_vec, 64'h0010);

      // 6: fill, mark busy, async reset between edges
      for (int i = 1; i < 16; i++) begin
         wr0_we = 1'b1; wr0_num = 4'(i); wr0_data = 32'h100 + 32'(i);
         tick();
      end
      idle();
      for (int i = 2; i < 16; i += 4) begin
         iss_en = 1'b1; iss_num = 4'(i);
         tick();
      end
      idle();
      rd_a_num = 4'd6; rd_b_num = 4'd15;
      #1;
      chk("t6_busy_vec", byp_busy_vec, 64'h4444);
      chk("t6_r6_data", nob_a_data, 64'h106);
      chk("t6_r6_busy", nob_a_busy, 64'h1);
      chk("t6_r15_data", byp_b_data, 64'h10F);
      #2;
      wr0_we = 1'b1; wr0_num = 4'd1; wr0_data = 32'hFFFF;
      rst_b = 1'b0;
      #1;
      chk("t6_rst_a_data", nob_a_data, 64'h0);
      chk("t6_rst_b_data", nob_b_data, 64'h0);
      chk("t6_rst_a_busy", nob_a_busy, 64'h0);
      chk("t6_rst_busy_vec", byp_busy_vec, 64'h0);
      tick();
      idle();
      rst_b = 1'b1;
      rd_a_num = 4'd1;
      tick();
      chk("t6_pending_wr_dropped", nob_a_data, 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
